// File: rtl/fdma_dual_arbiter.sv
// fdma_dual_arbiter: shares one FDMA slave port between two requesters.
// Write and read channels are arbitrated independently, each with its own
// round-robin pointer and IDLE -> ISSUE -> XFER -> IDLE sequencer. Zero-size
// bursts take a one-cycle DONE detour and never reach the master side.
//
// Ports:
//   ui_clk, ddr_rst        clock, asynchronous active-high reset
//   s_w*/s_r*              requester side, 2 lanes packed (lane 0 in low bits)
//   m_w*/m_r*              single FDMA master side
//   s_rdata                read data broadcast to both requesters
module fdma_dual_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned SW = 16,
  parameter int unsigned DW = 128
) (
  input  logic            ui_clk,
  input  logic            ddr_rst,
  // requester write side
  input  logic [1:0]      s_wareq,
  input  logic [2*AW-1:0] s_waddr,
  input  logic [2*SW-1:0] s_wsize,
  input  logic [2*DW-1:0] s_wdata,
  output logic [1:0]      s_wbusy,
  output logic [1:0]      s_wvalid,
  // requester read side
  input  logic [1:0]      s_rareq,
  input  logic [2*AW-1:0] s_raddr,
  input  logic [2*SW-1:0] s_rsize,
  output logic [1:0]      s_rbusy,
  output logic [1:0]      s_rvalid,
  output logic [DW-1:0]   s_rdata,
  // master write side
  output logic            m_wareq,
  output logic [AW-1:0]   m_waddr,
  output logic [SW-1:0]   m_wsize,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_wbusy,
  input  logic            m_wvalid,
  // master read side
  output logic            m_rareq,
  output logic [AW-1:0]   m_raddr,
  output logic [SW-1:0]   m_rsize,
  input  logic            m_rbusy,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // ---------------------------------------------------------------- write
  logic [1:0]    wst;
  logic          wgnt;
  logic          wlast;
  logic          wwin;
  logic [AW-1:0] waddr_win;
  logic [SW-1:0] wsize_win;

  // With both requesting, the one not served last wins; otherwise the sole requester.
  always_comb begin
    wwin      = (s_wareq == 2'b11) ? ~wlast : s_wareq[1];
    waddr_win = wwin ? s_waddr[2*AW-1:AW] : s_waddr[AW-1:0];
    wsize_win = wwin ? s_wsize[2*SW-1:SW] : s_wsize[SW-1:0];
  end

  always_ff @(posedge ui_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      wst     <= IDLE;
      wgnt    <= 1'b0;
      wlast   <= 1'b1;
      m_wareq <= 1'b0;
      m_waddr <= '0;
      m_wsize <= '0;
      s_wbusy <= 2'b00;
    end else begin
      case (wst)
        IDLE: begin
          if (!m_wbusy && (s_wareq != 2'b00)) begin
            wgnt    <= wwin;
            m_waddr <= waddr_win;
            m_wsize <= wsize_win;
            s_wbusy <= wwin ? 2'b10 : 2'b01;
            if (wsize_win == '0) begin
              wst <= DONE;
            end else begin
              m_wareq <= 1'b1;
              wst     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (m_wareq && m_wbusy) begin
            m_wareq <= 1'b0;
            wst     <= XFER;
          end
        end
        XFER: begin
          if (!m_wbusy) begin
            s_wbusy <= 2'b00;
            wlast   <= wgnt;
            wst     <= IDLE;
          end
        end
        default: begin  // DONE
          s_wbusy <= 2'b00;
          wlast   <= wgnt;
          wst     <= IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- read
  logic [1:0]    rst_st;
  logic          rgnt;
  logic          rlast;
  logic          rwin;
  logic [AW-1:0] raddr_win;
  logic [SW-1:0] rsize_win;

  always_comb begin
    rwin      = (s_rareq == 2'b11) ? ~rlast : s_rareq[1];
    raddr_win = rwin ? s_raddr[2*AW-1:AW] : s_raddr[AW-1:0];
    rsize_win = rwin ? s_rsize[2*SW-1:SW] : s_rsize[SW-1:0];
  end

  always_ff @(posedge ui_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      rst_st  <= IDLE;
      rgnt    <= 1'b0;
      rlast   <= 1'b1;
      m_rareq <= 1'b0;
      m_raddr <= '0;
      m_rsize <= '0;
      s_rbusy <= 2'b00;
    end else begin
      case (rst_st)
        IDLE: begin
          if (!m_rbusy && (s_rareq != 2'b00)) begin
            rgnt    <= rwin;
            m_raddr <= raddr_win;
            m_rsize <= rsize_win;
            s_rbusy <= rwin ? 2'b10 : 2'b01;
            if (rsize_win == '0) begin
              rst_st <= DONE;
            end else begin
              m_rareq <= 1'b1;
              rst_st  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (m_rareq && m_rbusy) begin
            m_rareq <= 1'b0;
            rst_st  <= XFER;
          end
        end
        XFER: begin
          if (!m_rbusy) begin
            s_rbusy <= 2'b00;
            rlast   <= rgnt;
            rst_st  <= IDLE;
          end
        end
        default: begin  // DONE
          s_rbusy <= 2'b00;
          rlast   <= rgnt;
          rst_st  <= IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- datapath
  always_comb begin
    m_wdata     = wgnt ? s_wdata[2*DW-1:DW] : s_wdata[DW-1:0];
    s_wvalid[0] = m_wvalid && (wst == XFER) && !wgnt;
    s_wvalid[1] = m_wvalid && (wst == XFER) && wgnt;
    s_rvalid[0] = m_rvalid && (rst_st == XFER) && !rgnt;
    s_rvalid[1] = m_rvalid && (rst_st == XFER) && rgnt;
    s_rdata     = m_rdata;
  end

endmodule

// File: tb/tb_fdma_dual_arbiter.sv
module tb_fdma_dual_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 16;
  localparam int unsigned DW = 128;

  logic            ui_clk = 1'b0;
  logic            ddr_rst = 1'b1;
  logic [1:0]      s_wareq = '0;
  logic [2*AW-1:0] s_waddr = '0;
  logic [2*SW-1:0] s_wsize = '0;
  logic [2*DW-1:0] s_wdata = '0;
  logic [1:0]      s_wbusy, s_wvalid;
  logic [1:0]      s_rareq = '0;
  logic [2*AW-1:0] s_raddr = '0;
  logic [2*SW-1:0] s_rsize = '0;
  logic [1:0]      s_rbusy, s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            m_wareq;
  logic [AW-1:0]   m_waddr;
  logic [SW-1:0]   m_wsize;
  logic [DW-1:0]   m_wdata;
  logic            m_wbusy = 1'b0;
  logic            m_wvalid = 1'b0;
  logic            m_rareq;
  logic [AW-1:0]   m_raddr;
  logic [SW-1:0]   m_rsize;
  logic            m_rbusy = 1'b0;
  logic            m_rvalid = 1'b0;
  logic [DW-1:0]   m_rdata = '0;

  fdma_dual_arbiter #(.AW(AW), .SW(SW), .DW(DW)) dut (
    .ui_clk(ui_clk), .ddr_rst(ddr_rst),
    .s_wareq(s_wareq), .s_waddr(s_waddr), .s_wsize(s_wsize), .s_wdata(s_wdata),
    .s_wbusy(s_wbusy), .s_wvalid(s_wvalid),
    .s_rareq(s_rareq), .s_raddr(s_raddr), .s_rsize(s_rsize),
    .s_rbusy(s_rbusy), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_wareq(m_wareq), .m_waddr(m_waddr), .m_wsize(m_wsize), .m_wdata(m_wdata),
    .m_wbusy(m_wbusy), .m_wvalid(m_wvalid),
    .m_rareq(m_rareq), .m_raddr(m_raddr), .m_rsize(m_rsize),
    .m_rbusy(m_rbusy), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial forever #5 ui_clk = ~ui_clk;

  // FDMA model: accept request, then one beat per cycle for 'size' cycles, then drop busy.
  int wcnt = 0;
  int rcnt = 0;
  always @(negedge ui_clk) begin
    if (ddr_rst) begin
      m_wbusy = 1'b0; m_wvalid = 1'b0; wcnt = 0;
    end else if (!m_wbusy) begin
      m_wvalid = 1'b0;
      if (m_wareq) begin m_wbusy = 1'b1; wcnt = int'(m_wsize); end
    end else if (wcnt != 0) begin
      m_wvalid = 1'b1; wcnt--;
    end else begin
      m_wvalid = 1'b0; m_wbusy = 1'b0;
    end
  end

  always @(negedge ui_clk) begin
    if (ddr_rst) begin
      m_rbusy = 1'b0; m_rvalid = 1'b0; rcnt = 0;
    end else if (!m_rbusy) begin
      m_rvalid = 1'b0;
      if (m_rareq) begin m_rbusy = 1'b1; rcnt = int'(m_rsize); end
    end else if (rcnt != 0) begin
      m_rvalid = 1'b1; m_rdata = m_rdata + 1'b1; rcnt--;
    end else begin
      m_rvalid = 1'b0; m_rbusy = 1'b0;
    end
  end

  // Monitor, sampled just after the falling edge.
  int wv0 = 0, wv1 = 0, rv0 = 0, rv1 = 0;
  int wareq_cyc = 0, rareq_cyc = 0, ovl = 0;
  int data_err = 0, both_err = 0, nogap_err = 0;
  logic [1:0] pw = '0, pr = '0;
  always @(negedge ui_clk) begin
    #1;
    if (s_wvalid[0]) wv0++;
    if (s_wvalid[1]) wv1++;
    if (s_rvalid[0]) rv0++;
    if (s_rvalid[1]) rv1++;
    if (m_wareq) wareq_cyc++;
    if (m_rareq) rareq_cyc++;
    if (m_wbusy && m_rbusy) ovl++;
    if (s_wvalid[0] && (m_wdata !== s_wdata[DW-1:0])) data_err++;
    if (s_wvalid[1] && (m_wdata !== s_wdata[2*DW-1:DW])) data_err++;
    if ((s_rvalid != 2'b00) && (s_rdata !== m_rdata)) data_err++;
    if ((s_wbusy == 2'b11) || (s_rbusy == 2'b11)) both_err++;
    if ((pw != 2'b00) && (s_wbusy != 2'b00) && (s_wbusy != pw)) nogap_err++;
    if ((pr != 2'b00) && (s_rbusy != 2'b00) && (s_rbusy != pr)) nogap_err++;
    pw = s_wbusy;
    pr = s_rbusy;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // sel: 0 write, 1 read, 2 both
  task automatic wait_done(input int sel, input string nm);
    int n = 0;
    while (n < 3000 &&
           (((sel != 1) && ((s_wbusy != 2'b00) || m_wbusy || m_wareq)) ||
            ((sel != 0) && ((s_rbusy != 2'b00) || m_rbusy || m_rareq)))) begin
      @(posedge ui_clk); #1;
      n++;
    end
    chk(nm, (n < 3000) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    ddr_rst = 1'b1;
    s_wareq = '0;
    s_rareq = '0;
    repeat (2) @(posedge ui_clk);
    #1;
    ddr_rst = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    int          req;
    logic [31:0] addr;
    logic [15:0] size;
    int          exp_b0;
    int          exp_b1;
    int          exp_areq;
  } vec_t;

  vec_t vt[5];
  vec_t v;
  int b0, b1, ac, n, o0;
  logic [1:0] exp_busy;

  initial begin
    vt[0] = '{rd: 1'b0, req: 0, addr: 32'h0000_2000, size: 16'd512, exp_b0: 512, exp_b1: 0, exp_areq: 1};
    vt[1] = '{rd: 1'b0, req: 1, addr: 32'h1234_5670, size: 16'd3,   exp_b0: 0,   exp_b1: 3, exp_areq: 1};
    vt[2] = '{rd: 1'b1, req: 1, addr: 32'h0000_8000, size: 16'd16,  exp_b0: 0,   exp_b1: 16, exp_areq: 1};
    vt[3] = '{rd: 1'b1, req: 0, addr: 32'hFFFF_FFF0, size: 16'd1,   exp_b0: 1,   exp_b1: 0, exp_areq: 1};
    vt[4] = '{rd: 1'b0, req: 1, addr: 32'h0000_0040, size: 16'd7,   exp_b0: 0,   exp_b1: 7, exp_areq: 1};
    s_wdata = {128'hB1B1_0000_1111_2222_3333_4444_5555_6666,
               128'hA0A0_9999_8888_7777_6666_5555_4444_3333};

    // Reset state
    repeat (3) @(posedge ui_clk);
    #1;
    chk("rst m_wareq", m_wareq, 0);
    chk("rst m_rareq", m_rareq, 0);
    chk("rst s_wbusy", s_wbusy, 0);
    chk("rst s_rbusy", s_rbusy, 0);
    chk("rst m_waddr", m_waddr, 0);
    chk("rst m_rsize", m_rsize, 0);
    ddr_rst = 1'b0;
    @(posedge ui_clk); #1;

    // Single transfers from the table
    for (int k = 0; k < 5; k++) begin
      v = vt[k];
      b0 = v.rd ? rv0 : wv0;
      b1 = v.rd ? rv1 : wv1;
      ac = v.rd ? rareq_cyc : wareq_cyc;
      exp_busy = (v.req == 1) ? 2'b10 : 2'b01;
      if (v.rd) begin
        s_raddr[v.req*AW +: AW] = v.addr;
        s_rsize[v.req*SW +: SW] = v.size;
        s_rareq[v.req] = 1'b1;
      end else begin
        s_waddr[v.req*AW +: AW] = v.addr;
        s_wsize[v.req*SW +: SW] = v.size;
        s_wareq[v.req] = 1'b1;
      end
      @(posedge ui_clk); #1;
      chk($sformatf("v%0d areq", k), v.rd ? m_rareq : m_wareq, 1);
      chk($sformatf("v%0d busy", k), v.rd ? s_rbusy : s_wbusy, exp_busy);
      chk($sformatf("v%0d addr", k), v.rd ? m_raddr : m_waddr, v.addr);
      chk($sformatf("v%0d size", k), v.rd ? m_rsize : m_wsize, v.size);
      // dropping the request after grant must not affect the transfer
      s_wareq = 2'b00;
      s_rareq = 2'b00;
      wait_done(v.rd ? 1 : 0, $sformatf("v%0d done", k));
      chk($sformatf("v%0d beats0", k), (v.rd ? rv0 : wv0) - b0, v.exp_b0);
      chk($sformatf("v%0d beats1", k), (v.rd ? rv1 : wv1) - b1, v.exp_b1);
      chk($sformatf("v%0d areq_cycles", k), (v.rd ? rareq_cyc : wareq_cyc) - ac, v.exp_areq);
    end

    // Both requesting continuously: grants alternate starting with req0
    do_reset();
    s_waddr = {32'h0000_0200, 32'h0000_0100};
    s_wsize = {16'd4, 16'd4};
    s_wareq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!m_wareq && n < 200) begin @(posedge ui_clk); #1; n++; end
      chk($sformatf("alt%0d grant", i), s_wbusy, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("alt%0d addr", i), m_waddr, (i % 2 == 1) ? 32'h200 : 32'h100);
      if (i == 3) s_wareq = 2'b00;
      n = 0;
      while (m_wareq && n < 200) begin @(posedge ui_clk); #1; n++; end
    end
    wait_done(0, "alt done");
    chk("alt onehot", both_err, 0);
    chk("alt idle gap", nogap_err, 0);

    // Zero-size write from req0 (last grant was req1)
    ac = wareq_cyc;
    s_wsize[SW-1:0] = '0;
    s_wareq = 2'b01;
    @(posedge ui_clk); #1;
    chk("zero busy on", s_wbusy, 2'b01);
    chk("zero no areq", m_wareq, 0);
    s_wareq = 2'b00;
    @(posedge ui_clk); #1;
    chk("zero busy off", s_wbusy, 2'b00);
    chk("zero areq cycles", wareq_cyc - ac, 0);
    s_waddr = {32'h0000_5100, 32'h0000_5000};
    s_wsize = {16'd5, 16'd5};
    s_wareq = 2'b11;
    @(posedge ui_clk); #1;
    chk("zero next grant", s_wbusy, 2'b10);
    chk("zero next addr", m_waddr, 32'h5100);
    s_wareq = 2'b00;
    wait_done(0, "zero next done");

    // Concurrent write (req0) and read (req1)
    b0 = wv0; b1 = rv1; o0 = ovl;
    s_waddr[AW-1:0] = 32'h0000_3000;
    s_wsize[SW-1:0] = 16'd20;
    s_raddr[2*AW-1:AW] = 32'h0000_4000;
    s_rsize[2*SW-1:SW] = 16'd20;
    s_wareq = 2'b01;
    s_rareq = 2'b10;
    @(posedge ui_clk); #1;
    chk("conc m_wareq", m_wareq, 1);
    chk("conc m_rareq", m_rareq, 1);
    chk("conc s_wbusy", s_wbusy, 2'b01);
    chk("conc s_rbusy", s_rbusy, 2'b10);
    s_wareq = 2'b00;
    s_rareq = 2'b00;
    wait_done(2, "conc done");
    chk("conc wbeats", wv0 - b0, 20);
    chk("conc rbeats", rv1 - b1, 20);
    chk("conc overlap", (ovl - o0 > 0) ? 1 : 0, 1);

    // Reset mid-transfer (last write grant was req0)
    s_waddr[AW-1:0] = 32'h0000_2000;
    s_wsize[SW-1:0] = 16'd512;
    s_wareq = 2'b01;
    @(posedge ui_clk); #1;
    s_wareq = 2'b00;
    repeat (20) @(posedge ui_clk);
    #1;
    chk("abort pre busy", s_wbusy, 2'b01);
    ddr_rst = 1'b1;
    #1;
    chk("abort s_wbusy", s_wbusy, 2'b00);
    chk("abort m_wareq", m_wareq, 0);
    chk("abort s_rbusy", s_rbusy, 2'b00);
    chk("abort m_waddr", m_waddr, 0);
    chk("abort m_wsize", m_wsize, 0);
    repeat (2) @(posedge ui_clk);
    #1;
    ddr_rst = 1'b0;
    @(posedge ui_clk); #1;
    s_waddr = {32'h0000_7100, 32'h0000_7000};
    s_wsize = {16'd3, 16'd3};
    s_wareq = 2'b11;
    @(posedge ui_clk); #1;
    chk("post rst grant", s_wbusy, 2'b01);
    chk("post rst addr", m_waddr, 32'h7000);
    s_wareq = 2'b00;
    wait_done(0, "post rst done");

    chk("onehot busy", both_err, 0);
    chk("idle gap", nogap_err, 0);
    chk("data path", data_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
